// File: rtl/mem_arbiter_nch.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_nch
// Brief    : Arbitrates N_CH request channels onto a byte-serial RAM port and
//            serialises 1/2/4-byte reads and writes. Round-robin or fixed
//            priority, request capture at grant, write-safe flush and IO
//            back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter_nch #(
   parameter int                N_CH    = 3,
   parameter int                ADDR_W  = 32,
   parameter bit                RR_MODE = 1'b1,
   parameter logic [ADDR_W-1:0] IO_BASE = 'h30000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rdy,
   input  logic                   flush,
   input  logic                   io_buffer_full,
   input  logic [N_CH-1:0]        req,
   input  logic [N_CH-1:0]        we,
   input  logic [N_CH*ADDR_W-1:0] addr,
   input  logic [N_CH*2-1:0]      size,
   input  logic [N_CH-1:0]        sgn,
   input  logic [N_CH*32-1:0]     wdata,
   output logic [N_CH-1:0]        done,
   output logic [31:0]            rdata,
   output logic                   busy,
   output logic [ADDR_W-1:0]      mem_a,
   output logic                   mem_wr,
   output logic [7:0]             mem_dout,
   input  logic [7:0]             mem_din
);

   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [CH_W-1:0]   ptr_q, ptr_d;
   logic [N_CH-1:0]   ch_q, ch_d;        // one-hot owner of the transaction
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        last_q, last_d;    // index of the final byte (n-1)
   logic [1:0]        cnt_q, cnt_d;      // bytes already handled
   logic              sgn_q, sgn_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [23:0]       rbuf_q, rbuf_d;    // read bytes gathered before the last
   logic [N_CH-1:0]   done_q, done_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [ADDR_W-1:0] mem_a_q, mem_a_d;
   logic              mem_wr_q, mem_wr_d;
   logic [7:0]        mem_dout_q, mem_dout_d;

   logic [N_CH-1:0]   w_elig, w_hi, w_cand, w_oh;
   logic              w_any;
   logic [CH_W-1:0]   w_enc      [N_CH+1];
   logic [ADDR_W-1:0] w_addr_mux [N_CH+1];
   logic [1:0]        w_size_mux [N_CH+1];
   logic [31:0]       w_wd_mux   [N_CH+1];
   logic [N_CH:0]     w_we_mux, w_sgn_mux;
   logic [1:0]        w_cnt_inc;
   logic              w_ext;

   assign w_enc[0]      = '0;
   assign w_addr_mux[0] = '0;
   assign w_size_mux[0] = '0;
   assign w_wd_mux[0]   = '0;
   assign w_we_mux[0]   = 1'b0;
   assign w_sgn_mux[0]  = 1'b0;

   // Per-channel eligibility plus AND-OR muxes that pick the winner's request
   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         logic [ADDR_W-1:0] ch_addr;
         assign ch_addr = addr[gi*ADDR_W +: ADDR_W];
         // A channel sits out its own done cycle because its req is still high
         assign w_elig[gi] = req[gi] & ~done_q[gi]
                           & ~(we[gi] & (ch_addr >= IO_BASE) & io_buffer_full)
                           & ~(~we[gi] & flush);
         assign w_hi[gi]          = (CH_W'(gi) > ptr_q);
         assign w_enc[gi+1]       = w_enc[gi] | ({CH_W{w_oh[gi]}} & CH_W'(gi));
         assign w_addr_mux[gi+1]  = w_addr_mux[gi] | ({ADDR_W{w_oh[gi]}} & ch_addr);
         assign w_size_mux[gi+1]  = w_size_mux[gi] | ({2{w_oh[gi]}} & size[gi*2 +: 2]);
         assign w_wd_mux[gi+1]    = w_wd_mux[gi] | ({32{w_oh[gi]}} & wdata[gi*32 +: 32]);
         assign w_we_mux[gi+1]    = w_we_mux[gi] | (w_oh[gi] & we[gi]);
         assign w_sgn_mux[gi+1]   = w_sgn_mux[gi] | (w_oh[gi] & sgn[gi]);
      end
   endgenerate

   // Round-robin prefers channels above the pointer, wrapping to the lowest
   generate
      if (RR_MODE) begin : g_rr
         assign w_cand = ((w_elig & w_hi) != '0) ? (w_elig & w_hi) : w_elig;
      end else begin : g_fp
         assign w_cand = w_elig;
      end
   endgenerate

   assign w_oh      = w_cand & (~w_cand + N_CH'(1));   // lowest set bit
   assign w_any     = |w_elig;
   assign w_cnt_inc = cnt_q + 2'd1;
   assign w_ext     = sgn_q & mem_din[7];

   // Next-state logic: grant in IDLE, byte stepping in RD/WR, frozen when !rdy
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      ch_d       = ch_q;
      addr_d     = addr_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      sgn_d      = sgn_q;
      wdata_d    = wdata_q;
      rbuf_d     = rbuf_q;
      done_d     = done_q;
      rdata_d    = rdata_q;
      mem_a_d    = mem_a_q;
      mem_wr_d   = mem_wr_q;
      mem_dout_d = mem_dout_q;
      if (rdy) begin
         done_d = '0;
         case (state_q)
            S_IDLE: begin
               if (w_any) begin
                  ptr_d   = w_enc[N_CH];
                  ch_d    = w_oh;
                  addr_d  = w_addr_mux[N_CH];
                  sgn_d   = w_sgn_mux[N_CH];
                  wdata_d = w_wd_mux[N_CH];
                  cnt_d   = 2'd0;
                  case (w_size_mux[N_CH])
                     2'd0:    last_d = 2'd0;
                     2'd1:    last_d = 2'd1;
                     default: last_d = 2'd3;
                  endcase
                  mem_a_d = w_addr_mux[N_CH];
                  if (w_we_mux[N_CH]) begin
                     mem_wr_d   = 1'b1;
                     mem_dout_d = w_wd_mux[N_CH][7:0];
                     state_d    = S_WR;
                  end else begin
                     mem_wr_d = 1'b0;
                     state_d  = S_RD;
                  end
               end
            end
            S_RD: begin
               if (flush) begin
                  // Abort wins even on the final byte edge
                  state_d = S_IDLE;
                  mem_a_d = '0;
               end else if (cnt_q == last_q) begin
                  case (last_q)
                     2'd0:    rdata_d = {{24{w_ext}}, mem_din};
                     2'd1:    rdata_d = {{16{w_ext}}, mem_din, rbuf_q[7:0]};
                     default: rdata_d = {mem_din, rbuf_q};
                  endcase
                  done_d  = ch_q;
                  state_d = S_IDLE;
                  mem_a_d = '0;
               end else begin
                  case (cnt_q)
                     2'd0:    rbuf_d[7:0]   = mem_din;
                     2'd1:    rbuf_d[15:8]  = mem_din;
                     default: rbuf_d[23:16] = mem_din;
                  endcase
                  cnt_d   = w_cnt_inc;
                  mem_a_d = addr_q + ADDR_W'(w_cnt_inc);
               end
            end
            S_WR: begin
               // Flush is deliberately ignored so a committed store never tears
               if (cnt_q == last_q) begin
                  mem_wr_d = 1'b0;
                  done_d   = ch_q;
                  state_d  = S_IDLE;
                  mem_a_d  = '0;
               end else begin
                  cnt_d   = w_cnt_inc;
                  mem_a_d = addr_q + ADDR_W'(w_cnt_inc);
                  case (w_cnt_inc)
                     2'd1:    mem_dout_d = wdata_q[15:8];
                     2'd2:    mem_dout_d = wdata_q[23:16];
                     default: mem_dout_d = wdata_q[31:24];
                  endcase
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ptr_q      <= CH_W'(N_CH - 1);
         ch_q       <= '0;
         addr_q     <= '0;
         last_q     <= 2'd0;
         cnt_q      <= 2'd0;
         sgn_q      <= 1'b0;
         wdata_q    <= '0;
         rbuf_q     <= '0;
         done_q     <= '0;
         rdata_q    <= '0;
         mem_a_q    <= '0;
         mem_wr_q   <= 1'b0;
         mem_dout_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         ch_q       <= ch_d;
         addr_q     <= addr_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         sgn_q      <= sgn_d;
         wdata_q    <= wdata_d;
         rbuf_q     <= rbuf_d;
         done_q     <= done_d;
         rdata_q    <= rdata_d;
         mem_a_q    <= mem_a_d;
         mem_wr_q   <= mem_wr_d;
         mem_dout_q <= mem_dout_d;
      end
   end

   assign done     = done_q;
   assign rdata    = rdata_q;
   assign busy     = (state_q != S_IDLE);
   assign mem_a    = mem_a_q;
   assign mem_wr   = mem_wr_q & rdy;   // no RAM write can slip out while frozen
   assign mem_dout = mem_dout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_nch.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter_nch
// Brief    : Directed self-checking bench for mem_arbiter_nch. Two instances
//            (round-robin and fixed priority) share one stimulus set; sel_fp
//            routes requests and outputs to the instance under test.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_nch;

   logic        clk = 1'b0;
   logic        rst, rdy, flush, io_full, sel_fp;
   logic [2:0]  req, we, sgn;
   logic [95:0] addr, wdata;
   logic [5:0]  size;

   logic [2:0]  req_rr, req_fp, done_rr, done_fp, done;
   logic [31:0] rdata_rr, rdata_fp, rdata, mem_a_rr, mem_a_fp, mem_a;
   logic        busy_rr, busy_fp, busy, mem_wr_rr, mem_wr_fp, mem_wr;
   logic [7:0]  dout_rr, dout_fp, mem_dout, din_rr, din_fp;

   logic [7:0]  ram [0:1023];
   logic [31:0] wa_q[$];
   logic [7:0]  wd_q[$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign req_rr   = sel_fp ? 3'b000 : req;
   assign req_fp   = sel_fp ? req : 3'b000;
   assign done     = sel_fp ? done_fp : done_rr;
   assign rdata    = sel_fp ? rdata_fp : rdata_rr;
   assign busy     = sel_fp ? busy_fp : busy_rr;
   assign mem_a    = sel_fp ? mem_a_fp : mem_a_rr;
   assign mem_wr   = sel_fp ? mem_wr_fp : mem_wr_rr;
   assign mem_dout = sel_fp ? dout_fp : dout_rr;
   // RAM byte is valid during the cycle its address is presented
   assign din_rr   = ram[mem_a_rr[9:0]];
   assign din_fp   = ram[mem_a_fp[9:0]];

   mem_arbiter_nch #(.N_CH(3), .ADDR_W(32), .RR_MODE(1'b1), .IO_BASE(32'h30000)) u_rr (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .io_buffer_full(io_full),
      .req(req_rr), .we(we), .addr(addr), .size(size), .sgn(sgn), .wdata(wdata),
      .done(done_rr), .rdata(rdata_rr), .busy(busy_rr), .mem_a(mem_a_rr),
      .mem_wr(mem_wr_rr), .mem_dout(dout_rr), .mem_din(din_rr)
   );

   mem_arbiter_nch #(.N_CH(3), .ADDR_W(32), .RR_MODE(1'b0), .IO_BASE(32'h30000)) u_fp (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .io_buffer_full(io_full),
      .req(req_fp), .we(we), .addr(addr), .size(size), .sgn(sgn), .wdata(wdata),
      .done(done_fp), .rdata(rdata_fp), .busy(busy_fp), .mem_a(mem_a_fp),
      .mem_wr(mem_wr_fp), .mem_dout(dout_fp), .mem_din(din_fp)
   );

   // Log every byte actually written to RAM (sampled mid-cycle)
   always @(negedge clk) begin
      if (mem_wr === 1'b1) begin
         wa_q.push_back(mem_a);
         wd_q.push_back(mem_dout);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int ch, input logic w, input logic [31:0] a,
                         input logic [1:0] sz, input logic sg, input logic [31:0] d);
      we[ch]             = w;
      addr[ch*32 +: 32]  = a;
      size[ch*2 +: 2]    = sz;
      sgn[ch]            = sg;
      wdata[ch*32 +: 32] = d;
   endtask

   task automatic test_reset();
      rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_full = 1'b0; sel_fp = 1'b0;
      req = '0; we = '0; sgn = '0; addr = '0; size = '0; wdata = '0;
      tick(); tick();
      checks++; if (done !== 3'b000) begin errors++; $display("FAIL reset_done got %b exp 000", done); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a got %h exp 0", mem_a); end
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got %b exp 0", mem_wr); end
      checks++; if (mem_dout !== 8'h0) begin errors++; $display("FAIL reset_mem_dout got %h exp 0", mem_dout); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_word_read();
      set_ch(1, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
      req[1] = 1'b1;
      tick();   // grant edge
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_rd_busy got %b exp 1", busy); end
      checks++; if (mem_a !== 32'h100) begin errors++; $display("FAIL wd_rd_a0 got %h exp 100", mem_a); end
      for (int k = 1; k < 4; k++) begin
         tick();
         checks++;
         if (mem_a !== 32'h100 + k) begin errors++; $display("FAIL wd_rd_a%0d got %h exp %h", k, mem_a, 32'h100 + k); end
         checks++;
         if (done !== 3'b000) begin errors++; $display("FAIL wd_rd_early_done%0d got %b exp 000", k, done); end
      end
      tick();   // fourth edge after grant
      checks++; if (done !== 3'b010) begin errors++; $display("FAIL wd_rd_done got %b exp 010", done); end
      checks++; if (rdata !== 32'h44332211) begin errors++; $display("FAIL wd_rd_data got %h exp 44332211", rdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_rd_idle got %b exp 0", busy); end
      req[1] = 1'b0;
      tick();
      checks++; if (done !== 3'b000) begin errors++; $display("FAIL wd_rd_done_pulse got %b exp 000", done); end
   endtask

   task automatic test_sign_extend();
      set_ch(2, 1'b0, 32'h80, 2'd0, 1'b1, 32'h0);
      req[2] = 1'b1;
      tick(); tick();
      checks++; if (done !== 3'b100) begin errors++; $display("FAIL sx1_done got %b exp 100", done); end
      checks++; if (rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL sx1_data got %h exp FFFFFF80", rdata); end
      req[2] = 1'b0; sgn[2] = 1'b0;
      tick();
      req[2] = 1'b1;
      tick(); tick();
      checks++; if (done !== 3'b100) begin errors++; $display("FAIL sx0_done got %b exp 100", done); end
      checks++; if (rdata !== 32'h00000080) begin errors++; $display("FAIL sx0_data got %h exp 00000080", rdata); end
      req[2] = 1'b0;
      tick();
   endtask

   // All three channels hold byte reads; completion order mirrors grant order.
   // A channel sits out its own done cycle, so under fixed priority ch1 takes
   // that slot and ch0 then beats ch2 again: 0,1,0,1.
   task automatic test_arbitration(input logic fp);
      logic [2:0] seq[$];
      logic [2:0] exp_seq [4];
      logic [2:0] got;
      if (fp) begin
         exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b001; exp_seq[3] = 3'b010;
      end else begin
         exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
      end
      sel_fp = fp;
      set_ch(0, 1'b0, 32'h80, 2'd0, 1'b0, 32'h0);
      set_ch(1, 1'b0, 32'h81, 2'd0, 1'b0, 32'h0);
      set_ch(2, 1'b0, 32'h82, 2'd0, 1'b0, 32'h0);
      req = 3'b111;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done != 3'b000) seq.push_back(done);
      end
      req = 3'b000;
      tick(); tick(); tick();
      for (int i = 0; i < 4; i++) begin
         got = (i < seq.size()) ? seq[i] : 3'bxxx;
         checks++;
         if (got !== exp_seq[i]) begin
            errors++; $display("FAIL arb_fp%0b_grant%0d got %b exp %b", fp, i, got, exp_seq[i]);
         end
      end
      sel_fp = 1'b0;
   endtask

   task automatic test_io_backpressure();
      logic saw;
      wa_q.delete(); wd_q.delete();
      io_full = 1'b1;
      set_ch(0, 1'b0, 32'h80, 2'd0, 1'b0, 32'h0);
      set_ch(2, 1'b1, 32'h30000, 2'd1, 1'b0, 32'h0000BEEF);
      req = 3'b101;
      tick(); tick();
      checks++; if (done !== 3'b001) begin errors++; $display("FAIL io_rd_first got %b exp 001", done); end
      checks++; if (rdata !== 32'h80) begin errors++; $display("FAIL io_rd_data got %h exp 00000080", rdata); end
      req[0] = 1'b0;
      tick(); tick(); tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL io_held_busy got %b exp 0", busy); end
      checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL io_held_writes got %0d exp 0", wa_q.size()); end
      io_full = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 10 && !saw; i++) begin
         tick();
         if (done[2] === 1'b1) saw = 1'b1;
      end
      checks++; if (saw !== 1'b1) begin errors++; $display("FAIL io_wr_done got %b exp 1", saw); end
      req[2] = 1'b0;
      tick();
      checks++;
      if (wa_q.size() != 2) begin
         errors++; $display("FAIL io_wr_count got %0d exp 2", wa_q.size());
      end else begin
         checks++; if (wd_q[0] !== 8'hEF || wa_q[0] !== 32'h30000) begin errors++; $display("FAIL io_wr_b0 got %h@%h exp EF@30000", wd_q[0], wa_q[0]); end
         checks++; if (wd_q[1] !== 8'hBE || wa_q[1] !== 32'h30001) begin errors++; $display("FAIL io_wr_b1 got %h@%h exp BE@30001", wd_q[1], wa_q[1]); end
      end
   endtask

   task automatic test_flush();
      set_ch(1, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
      req[1] = 1'b1;
      tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0; req[1] = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_rd_busy got %b exp 0", busy); end
      checks++; if (done !== 3'b000) begin errors++; $display("FAIL flush_rd_done got %b exp 000", done); end
      tick(); tick(); tick();
      checks++; if (done !== 3'b000) begin errors++; $display("FAIL flush_rd_late_done got %b exp 000", done); end

      wa_q.delete(); wd_q.delete();
      set_ch(0, 1'b1, 32'h200, 2'd2, 1'b0, 32'hA1B2C3D4);
      req[0] = 1'b1;
      tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick(); tick();
      checks++; if (done !== 3'b001) begin errors++; $display("FAIL flush_wr_done got %b exp 001", done); end
      req[0] = 1'b0;
      tick();
      checks++;
      if (wa_q.size() != 4) begin
         errors++; $display("FAIL flush_wr_count got %0d exp 4", wa_q.size());
      end else begin
         checks++;
         if ({wd_q[3], wd_q[2], wd_q[1], wd_q[0]} !== 32'hA1B2C3D4) begin
            errors++; $display("FAIL flush_wr_data got %h%h%h%h exp A1B2C3D4", wd_q[3], wd_q[2], wd_q[1], wd_q[0]);
         end
         checks++;
         if (wa_q[0] !== 32'h200 || wa_q[3] !== 32'h203) begin
            errors++; $display("FAIL flush_wr_addr got %h..%h exp 200..203", wa_q[0], wa_q[3]);
         end
      end
   endtask

   task automatic test_rdy_and_wrap();
      wa_q.delete(); wd_q.delete();
      set_ch(1, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
      req[1] = 1'b1;
      tick(); tick();
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (mem_a !== 32'h101 || busy !== 1'b1 || done !== 3'b000) begin
            errors++; $display("FAIL rdy_hold%0d got a=%h busy=%b done=%b exp a=101 busy=1 done=000", i, mem_a, busy, done);
         end
      end
      rdy = 1'b1;
      tick(); tick();
      checks++; if (done !== 3'b000) begin errors++; $display("FAIL rdy_early_done got %b exp 000", done); end
      tick();
      checks++; if (done !== 3'b010) begin errors++; $display("FAIL rdy_done got %b exp 010", done); end
      checks++; if (rdata !== 32'h44332211) begin errors++; $display("FAIL rdy_data got %h exp 44332211", rdata); end
      checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL rdy_no_write got %0d exp 0", wa_q.size()); end
      req[1] = 1'b0;
      tick();

      wa_q.delete(); wd_q.delete();
      set_ch(0, 1'b1, 32'hFFFFFFFE, 2'd2, 1'b0, 32'h04030201);
      req[0] = 1'b1;
      tick(); tick(); tick(); tick(); tick();
      checks++; if (done !== 3'b001) begin errors++; $display("FAIL wrap_done got %b exp 001", done); end
      req[0] = 1'b0;
      tick();
      checks++;
      if (wa_q.size() != 4) begin
         errors++; $display("FAIL wrap_count got %0d exp 4", wa_q.size());
      end else begin
         checks++;
         if (wa_q[0] !== 32'hFFFFFFFE || wa_q[1] !== 32'hFFFFFFFF || wa_q[2] !== 32'h0 || wa_q[3] !== 32'h1) begin
            errors++; $display("FAIL wrap_addr got %h %h %h %h exp FFFFFFFE FFFFFFFF 0 1", wa_q[0], wa_q[1], wa_q[2], wa_q[3]);
         end
         checks++;
         if ({wd_q[3], wd_q[2], wd_q[1], wd_q[0]} !== 32'h04030201) begin
            errors++; $display("FAIL wrap_data got %h%h%h%h exp 04030201", wd_q[3], wd_q[2], wd_q[1], wd_q[0]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
      ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
      ram[10'h080] = 8'h80; ram[10'h081] = 8'h81; ram[10'h082] = 8'h82;
      test_reset();
      test_word_read();
      test_sign_extend();
      test_arbitration(1'b0);
      test_arbitration(1'b1);
      test_io_backpressure();
      test_flush();
      test_rdy_and_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
